// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared opcode, instruction-format and fetch FSM definitions
//
// Shared by the fetch unit, the instruction memory and the datapath decoder.
// Contents: instruction word layout {opcode[16:12], operand[11:0]}, opcode
// constants, fetch FSM state encoding and the branch-taken helper.
package instr_fetch_pkg;

  localparam int OPCODE_W  = 5;
  localparam int OPERAND_W = 12;

  typedef struct packed {
    logic [OPCODE_W-1:0]  opcode;
    logic [OPERAND_W-1:0] operand;
  } instr_t;

  // Control-flow opcodes the fetch unit acts on; everything else belongs to
  // the datapath decoder and is passed through untouched.
  localparam logic [OPCODE_W-1:0] OP_JPNZ  = 5'd24;
  localparam logic [OPCODE_W-1:0] OP_JMPZ  = 5'd26;
  localparam logic [OPCODE_W-1:0] OP_NOP   = 5'd28;
  localparam logic [OPCODE_W-1:0] OP_ENDOP = 5'd31;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  // JPNZ jumps on a non-zero accumulator, JMPZ on a zero accumulator.
  function automatic logic is_taken_branch(input logic [OPCODE_W-1:0] op,
                                           input logic z);
    return ((op == OP_JPNZ) && !z) || ((op == OP_JMPZ) && z);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch unit bundle: control inputs, imem port, instruction output
//
// master: the fetch unit (drives imem_addr and the presented instruction)
// slave : the environment (datapath control + instruction memory)
//   start, stall, z_flag : control from the datapath
//   imem_addr / imem_data: instruction memory read, data one cycle after address
//   opcode, operand, instr_valid, pc, halted : presented instruction and status
interface instr_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int INSTR_W = 17
);
  logic                 start;
  logic                 stall;
  logic                 z_flag;
  logic [ADDR_W-1:0]    imem_addr;
  logic [INSTR_W-1:0]   imem_data;
  logic [OPCODE_W-1:0]  opcode;
  logic [OPERAND_W-1:0] operand;
  logic                 instr_valid;
  logic [ADDR_W-1:0]    pc;
  logic                 halted;

  modport master (
    input  start, stall, z_flag, imem_data,
    output imem_addr, opcode, operand, instr_valid, pc, halted
  );

  modport slave (
    output start, stall, z_flag, imem_data,
    input  imem_addr, opcode, operand, instr_valid, pc, halted
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit with branch resolve, stall replay and halt
//
// Ports:
//   clk, rstn          : clock, synchronous active-low reset
//   fif (master)       : start/stall/z_flag in, imem_addr out, imem_data in,
//                        opcode/operand/instr_valid/pc/halted out
//   instr_count[15:0]  : consumed-instruction counter, saturating
//                        (present only when IFETCH_PERF_EN is defined)
//
// Pipeline: fetch address (cycle A) -> memory data (A+1) -> presented (A+2).
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int INSTR_W = 17
) (
  input  logic           clk,
  input  logic           rstn,
  instr_fetch_if.master  fif
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0]    instr_count
`endif
);

  logic [1:0]           state_q,    state_d;
  logic [ADDR_W-1:0]    fetch_pc_q, fetch_pc_d;  // address issued when not stalled
  logic [ADDR_W-1:0]    data_pc_q,  data_pc_d;   // address of the word on imem_data
  logic                 data_vld_q, data_vld_d;  // imem_data carries a wanted word
  logic [OPCODE_W-1:0]  opcode_q,   opcode_d;
  logic [OPERAND_W-1:0] operand_q,  operand_d;
  logic [ADDR_W-1:0]    pc_q,       pc_d;
  logic                 valid_q,    valid_d;
  logic                 halted_q,   halted_d;

  instr_t mem_word;
  logic   consume;
  logic   taken;
  logic   endop;

  assign mem_word = instr_t'(fif.imem_data);
  assign consume  = (state_q == ST_RUN) && valid_q && !fif.stall;
  assign endop    = consume && (opcode_q == OP_ENDOP);
  assign taken    = consume && is_taken_branch(opcode_q, fif.z_flag);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    data_pc_d  = data_pc_q;
    data_vld_d = data_vld_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    halted_d   = halted_q;

    case (state_q)
      ST_RUN: begin
        // A stall freezes the whole pipeline; the memory replays data_pc_q.
        if (!fif.stall) begin
          if (endop) begin
            state_d    = ST_HALT;
            halted_d   = 1'b1;
            valid_d    = 1'b0;
            data_vld_d = 1'b0;
          end else if (taken) begin
            fetch_pc_d = operand_q[ADDR_W-1:0];
            data_vld_d = 1'b0;
            valid_d    = 1'b0;
          end else begin
            valid_d = data_vld_q;
            if (data_vld_q) begin
              opcode_d  = mem_word.opcode;
              operand_d = mem_word.operand;
              pc_d      = data_pc_q;
            end
            data_pc_d  = fetch_pc_q;
            data_vld_d = 1'b1;
            fetch_pc_d = ADDR_W'(fetch_pc_q + 1'b1);
          end
        end
      end
      default: begin
        if (fif.start) begin
          state_d    = ST_RUN;
          halted_d   = 1'b0;
          fetch_pc_d = '0;
          data_vld_d = 1'b0;
          valid_d    = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= '0;
      data_pc_q  <= '0;
      data_vld_q <= 1'b0;
      opcode_q   <= '0;
      operand_q  <= '0;
      pc_q       <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      data_pc_q  <= data_pc_d;
      data_vld_q <= data_vld_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
    end
  end

  // While stalled, re-request the word already on imem_data so it is not lost.
  assign fif.imem_addr   = ((state_q == ST_RUN) && fif.stall) ? data_pc_q : fetch_pc_q;
  assign fif.opcode      = opcode_q;
  assign fif.operand     = operand_q;
  assign fif.instr_valid = valid_q;
  assign fif.pc          = pc_q;
  assign fif.halted      = halted_q;

`ifdef IFETCH_PERF_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if ((state_q != ST_RUN) && fif.start) begin
      count_d = '0;
    end else if (consume && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign instr_count = count_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch (model + directed + random)
module tb_instr_fetch;

  logic clk;
  logic rstn;
  instr_fetch_if #(.ADDR_W(11), .INSTR_W(17)) fif ();
`ifdef IFETCH_PERF_EN
  logic [15:0] instr_count;
`endif

  instr_fetch #(.ADDR_W(11), .INSTR_W(17)) dut (
    .clk  (clk),
    .rstn (rstn),
    .fif  (fif)
`ifdef IFETCH_PERF_EN
    ,
    .instr_count (instr_count)
`endif
  );

  logic [16:0] mem [0:2047];
  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // behavioural model state
  bit m_run, m_halted, m_valid;
  int m_pc, m_pending, m_next, m_count;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // registered instruction memory
  initial begin
    fif.imem_data = '0;
    forever begin
      @(posedge clk);
      fif.imem_data <= mem[fif.imem_addr];
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an instruction is presented a fixed number of unstalled cycles
  // after start or a taken branch; otherwise each consumption presents the
  // next sequential address.
  initial begin
    int op, opr;
    m_run = 0; m_halted = 0; m_valid = 0; m_pc = 0; m_pending = 0; m_next = 0; m_count = 0;
    forever begin
      @(posedge clk);
      if (!rstn) begin
        m_run = 0; m_halted = 0; m_valid = 0; m_pc = 0; m_pending = 0; m_count = 0;
      end else if (!m_run) begin
        if (fif.start) begin
          m_run = 1; m_halted = 0; m_valid = 0; m_pending = 2; m_next = 0; m_count = 0;
        end
      end else if (!fif.stall) begin
        if (m_valid) begin
          op  = int'(mem[m_pc][16:12]);
          opr = int'(mem[m_pc][11:0]);
          if (m_count < 65535) m_count++;
          if (op == 31) begin
            m_run = 0; m_halted = 1; m_valid = 0;
          end else if ((op == 24 && !fif.z_flag) || (op == 26 && fif.z_flag)) begin
            m_valid = 0; m_pending = 2; m_next = opr % 2048;
          end else begin
            m_pc = (m_pc + 1) % 2048;
          end
        end else begin
          m_pending--;
          if (m_pending == 0) begin
            m_valid = 1; m_pc = m_next;
          end
        end
      end
    end
  end

  // every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        cmp("instr_valid", fif.instr_valid, m_valid);
        cmp("halted", fif.halted, m_halted);
        if (m_valid) begin
          cmp("pc", fif.pc, m_pc);
          cmp("opcode", fif.opcode, mem[m_pc][16:12]);
          cmp("operand", fif.operand, mem[m_pc][11:0]);
        end
`ifdef IFETCH_PERF_EN
        cmp("instr_count", instr_count, m_count);
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_vals(input string tag);
    cmp({tag, "_valid"}, fif.instr_valid, 0);
    cmp({tag, "_halted"}, fif.halted, 0);
    cmp({tag, "_pc"}, fif.pc, 0);
    cmp({tag, "_opcode"}, fif.opcode, 0);
    cmp({tag, "_operand"}, fif.operand, 0);
    cmp({tag, "_imem_addr"}, fif.imem_addr, 0);
`ifdef IFETCH_PERF_EN
    cmp({tag, "_count"}, instr_count, 0);
`endif
  endtask

  // Advance until the given pc is presented, steering z_flag so that
  // branches passed on the way are not taken.
  task automatic run_until(input int target);
    int n = 0;
    fif.stall = 0;
    while (!(fif.instr_valid && int'(fif.pc) == target) && n < 3000) begin
      fif.z_flag = (fif.opcode == 5'd24);
      step();
      n++;
    end
    cmp("reach_pc", (fif.instr_valid && int'(fif.pc) == target), 1);
  endtask

  initial begin
    rstn = 0;
    fif.start = 0; fif.stall = 0; fif.z_flag = 0;
    for (int i = 0; i < 2048; i++) mem[i] = {5'($urandom_range(0, 23)), 12'($urandom)};
    mem[47] = {5'd24, 12'h000};
    mem[60] = {5'd26, 12'hFFF};
    mem[98] = {5'd31, 12'h000};

    step();
    chk_en = 1;
    step();
    check_reset_vals("reset");
    rstn = 1;
    step(); step();

    // start at cycle 5 (counting reset edges from 1)
    fif.start = 1;
    step();
    fif.start = 0;
    #1;
    cmp("start_imem_addr", fif.imem_addr, 0);
    cmp("start_bubble", fif.instr_valid, 0);
    step(); step();
    cmp("first_valid", fif.instr_valid, 1);
    cmp("first_pc", fif.pc, 0);
    cmp("model_first_pc", m_pc, 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      cmp("seq_pc", fif.pc, k);
    end

    // stall for 3 cycles while pc=4 is presented
    fif.stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      cmp("stall_pc", fif.pc, 4);
      cmp("stall_replay_addr", fif.imem_addr, 5);
      step();
    end
    fif.stall = 0;
    cmp("release_pc", fif.pc, 4);
    step();
    cmp("after_stall_pc", fif.pc, 5);
    step();
    cmp("after_stall_pc2", fif.pc, 6);

    // JPNZ taken
    run_until(47);
    fif.z_flag = 0;
    step();
    #1;
    cmp("jpnz_addr", fif.imem_addr, 0);
    cmp("jpnz_bubble1", fif.instr_valid, 0);
    step();
    cmp("jpnz_bubble2", fif.instr_valid, 0);
    step();
    cmp("jpnz_target_valid", fif.instr_valid, 1);
    cmp("jpnz_target_pc", fif.pc, 0);

    // JPNZ not taken
    run_until(47);
    fif.z_flag = 1;
    step();
    cmp("jpnz_nt_valid", fif.instr_valid, 1);
    cmp("jpnz_nt_pc", fif.pc, 48);

    // JMPZ to 0xFFF -> 2047, then wrap
    run_until(60);
    fif.z_flag = 1;
    step();
    #1;
    cmp("jmpz_addr", fif.imem_addr, 2047);
    cmp("jmpz_bubble", fif.instr_valid, 0);
    fif.z_flag = 0;
    step(); step();
    cmp("jmpz_target_pc", fif.pc, 2047);
    cmp("model_jmpz_target", m_pc, 2047);
    step();
    cmp("wrap_pc", fif.pc, 0);

    // ENDOP at 98
    run_until(60);
    fif.z_flag = 0;
    step();
    run_until(98);
    step();
    cmp("endop_halted", fif.halted, 1);
    cmp("endop_valid", fif.instr_valid, 0);
    cmp("endop_addr", fif.imem_addr, 100);
    step(); step();
    cmp("halt_addr_frozen", fif.imem_addr, 100);

    // restart from HALT
    fif.start = 1;
    step();
    fif.start = 0;
    cmp("restart_halted", fif.halted, 0);
    step(); step();
    cmp("restart_pc", fif.pc, 0);
    cmp("restart_valid", fif.instr_valid, 1);

    // reset during branch flush
    run_until(47);
    fif.z_flag = 0;
    step();
    rstn = 0;
    step();
    check_reset_vals("rst_flush");
    rstn = 1;
    step();

    // reset during stall
    fif.start = 1;
    step();
    fif.start = 0;
    run_until(4);
    fif.stall = 1;
    step();
    rstn = 0;
    step();
    check_reset_vals("rst_stall");
    rstn = 1;
    fif.stall = 0;
    step();

    // randomized phase with branches/ENDOP anywhere
    rstn = 0;
    for (int i = 0; i < 2048; i++) mem[i] = 17'($urandom);
    step();
    rstn = 1;
    for (int c = 0; c < 5000; c++) begin
      fif.start  = ($urandom_range(0, 7) == 0);
      fif.stall  = ($urandom_range(0, 3) == 0);
      fif.z_flag = 1'($urandom);
      rstn       = ($urandom_range(0, 299) != 0);
      step();
    end
    rstn = 1; fif.start = 0; fif.stall = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 11: instruction memory address width (2048 words).
REQ-002 SHALL have parameter INSTR_W, default 17: instruction width, {opcode[16:12], operand[11:0]}.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: begin execution at address 0 (IDLE/HALT only).
REQ-006 SHALL have port stall, input, 1: the datapath cannot accept an instruction this cycle.
REQ-007 SHALL have port z_flag, input, 1: accumulator-zero flag from the datapath.
REQ-008 SHALL have port imem_addr, output, ADDR_W: read address to the instruction memory.
REQ-009 SHALL have port imem_data, input, INSTR_W: registered memory output, returned 1 cycle after imem_addr.
REQ-010 SHALL have port opcode, output, 5: opcode of the presented instruction.
REQ-011 SHALL have port operand, output, 12: operand of the presented instruction.
REQ-012 SHALL have port instr_valid, output, 1: opcode/operand hold a valid instruction.
REQ-013 SHALL have port pc, output, ADDR_W: address of the presented instruction.
REQ-014 SHALL have port halted, output, 1: ENDOP has been consumed.

Function
REQ-015 SHALL implement states IDLE, RUN and HALT; IDLE->RUN on start; RUN->HALT on ENDOP consumption; HALT->RUN on start; start in RUN is ignored.
REQ-016 SHALL treat an instruction as consumed in any cycle with instr_valid=1 and stall=0.
REQ-017 SHALL issue sequential fetch addresses in RUN, one per unstalled cycle, with the fetch PC incrementing modulo 2^ADDR_W (2047 wraps to 0).
REQ-018 SHALL drive imem_addr to address 0 in the cycle after start, with the first instr_valid=1 two cycles after that (start at cycle s -> valid at s+3).
REQ-019 SHALL, while stall=1, hold opcode/operand/pc/instr_valid and the fetch PC, and drive imem_addr to the address whose data is on imem_data, so the in-flight word is replayed and never lost.
REQ-020 SHALL evaluate branches at consumption, with JPNZ (opcode 24) taken when z_flag=0 and JMPZ (opcode 26) taken when z_flag=1, sampling z_flag in the consuming cycle.
REQ-021 SHALL use operand[ADDR_W-1:0] as the target of a taken branch, ignoring the upper operand bits.
REQ-022 SHALL, on a taken branch consumed at cycle t, drive imem_addr=target at t+1, discard the two in-flight words (instr_valid=0 at t+1 and t+2), and present the target at t+3.
REQ-023 SHALL treat not-taken branches like any other instruction, with no bubble.
REQ-024 SHALL, on ENDOP (opcode 31) consumption, enter HALT in the next cycle: instr_valid=0, halted=1, imem_addr frozen, in-flight words discarded.
REQ-025 SHALL pass all other opcodes (including NOP, 28) through unmodified, since decode beyond branch/ENDOP belongs to the datapath.
REQ-026 SHALL, when start and a taken branch coincide, ignore start.
REQ-027 SHALL clear halted when start is accepted in HALT.

Reset
REQ-028 SHALL, on rstn=0 at a clock edge, enter IDLE with imem_addr=0, pc=0, opcode=0, operand=0, instr_valid=0, halted=0, and discard in-flight fetches.
REQ-029 SHALL honour reset in any state, including mid-stall and mid-branch-flush, taking priority over start.

Configuration
REQ-030 SHALL, when IFETCH_PERF_EN is defined, add output instr_count[15:0], cleared by reset and by an accepted start, incremented per consumed instruction, saturating at 65535.
REQ-031 SHALL, without IFETCH_PERF_EN, have no instr_count port and no counter logic.

Structure
REQ-032 SHALL place the opcode localparams (JPNZ=24, JMPZ=26, NOP=28, ENDOP=31, ...) and the FSM state encoding in a shared package, also used by the instruction memory and the datapath decoder.
REQ-033 SHALL be a single module with no sub-modules; the branch-resolve logic is too small to split out.

Verification
REQ-034 SHALL cover: reset, then start at cycle 5 -> imem_addr=0 at 6, instr_valid=1 with pc=0 at 8, then pc 1,2,3 on consecutive cycles.
REQ-035 SHALL cover: stall=1 for 3 cycles while pc=4 is presented -> pc=4 held throughout, then pc=5 immediately after release with no word lost or duplicated.
REQ-036 SHALL cover: JPNZ operand 0 at pc=47 with z_flag=0 -> two bubbles, then pc=0; repeat with z_flag=1 -> pc=48 next, no bubble.
REQ-037 SHALL cover: JMPZ operand 0xFFF (ADDR_W=11) with z_flag=1 -> target 2047; the sequential fetch then wraps to pc=0.
REQ-038 SHALL cover: ENDOP at pc=98 -> halted=1 and instr_valid=0 next cycle; start -> halted=0 and pc=0 three cycles later.
REQ-039 SHALL cover: rstn=0 during a branch flush and during a stall -> all outputs at reset values next cycle; with IFETCH_PERF_EN, instr_count equals the number of consumed instructions.
